game_round_ctrl: RTL

- Sequencer for one whack-a-mole round.
- Owns a single shared prescale counter and derives a base tick from it. Uses the tick to schedule mole pop-up windows, gap intervals and the round countdown.
- Sits between the player-input debounce logic and the display/score logic.
- Emits mole visibility, mole position, hit/miss pulses, time remaining and game-over.

---
 rtl/game_round_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/game_round_ctrl.sv
// Whack-a-mole round sequencer: shared prescaler, gap/up windows,
// round countdown, hit/miss pulses and game-over.
module game_round_ctrl #(
  parameter int unsigned TICK_CYCLES = 32'd10000000,
  parameter int unsigned ROUND_TICKS = 600,
  parameter int unsigned UP_TICKS    = 10,
  parameter int unsigned GAP_TICKS   = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       hit,
  input  logic [1:0] level,
  output logic       mole_up,
  output logic [3:0] mole_pos,
  output logic       hit_ok,
  output logic       miss,
  output logic [9:0] time_left,
  output logic       game_over,
  output logic       tick
);

  typedef enum logic [1:0] {IDLE, GAP, UP, DONE} state_t;

  localparam logic [31:0] TICK_LAST = 32'(TICK_CYCLES - 1);
  localparam logic [9:0]  ROUND_T   = 10'(ROUND_TICKS);
  localparam logic [7:0]  UP_T      = 8'(UP_TICKS);
  localparam logic [7:0]  GAP_T     = 8'(GAP_TICKS);

  state_t      state;
  logic [31:0] prescaler;
  logic [7:0]  phase_cnt;
  logic [3:0]  lfsr;
  logic        running;
  logic        itick;
  logic        final_tick;
  logic [7:0]  up_shift;
  logic [7:0]  up_load;

  assign running    = (state == GAP) || (state == UP);
  assign itick      = running && (prescaler == TICK_LAST);
  assign final_tick = itick && (time_left == 10'd1);
  assign up_shift   = UP_T >> level;
  assign up_load    = (up_shift == 8'd0) ? 8'd1 : up_shift;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prescaler <= '0;
      phase_cnt <= '0;
      lfsr      <= 4'b1001;
      mole_up   <= 1'b0;
      mole_pos  <= '0;
      hit_ok    <= 1'b0;
      miss      <= 1'b0;
      time_left <= ROUND_T;
      game_over <= 1'b0;
      tick      <= 1'b0;
    end else begin
      lfsr   <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      tick   <= itick;
      hit_ok <= 1'b0;
      miss   <= 1'b0;
      if (!running || itick) prescaler <= '0;
      else                   prescaler <= prescaler + 32'd1;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= GAP;
            phase_cnt <= GAP_T;
            time_left <= ROUND_T;
            game_over <= 1'b0;
          end
        end
        GAP: begin
          if (final_tick) begin
            state     <= DONE;
            time_left <= '0;
            mole_up   <= 1'b0;
            game_over <= 1'b1;
          end else if (itick) begin
            time_left <= time_left - 10'd1;
            if (phase_cnt == 8'd1) begin
              state     <= UP;
              phase_cnt <= up_load;
              mole_pos  <= lfsr;
              mole_up   <= 1'b1;
            end else begin
              phase_cnt <= phase_cnt - 8'd1;
            end
          end
        end
        UP: begin
          // end of round outranks a hit landing on the same tick
          if (final_tick) begin
            state     <= DONE;
            time_left <= '0;
            mole_up   <= 1'b0;
            game_over <= 1'b1;
          end else if (hit) begin
            state     <= GAP;
            mole_up   <= 1'b0;
            hit_ok    <= 1'b1;
            phase_cnt <= GAP_T;
            if (itick) time_left <= time_left - 10'd1;
          end else if (itick) begin
            time_left <= time_left - 10'd1;
            if (phase_cnt == 8'd1) begin
              state     <= GAP;
              mole_up   <= 1'b0;
              miss      <= 1'b1;
              phase_cnt <= GAP_T;
            end else begin
              phase_cnt <= phase_cnt - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
